// File: rtl/mem_decoder_if.sv
// mem_decoder_if: character input, rotor control and output handshake of mem_decoder
interface mem_decoder_if;
  logic [7:0] in;
  logic [1:0] setting;
  logic       in_valid;
  logic       in_ready;
  logic       load;
  logic [4:0] start_pos;
  logic [7:0] out;
  logic       out_valid;
  logic       out_ready;
  logic [4:0] rotor;
  modport master (output in, setting, in_valid, load, start_pos, out_ready,
                  input in_ready, out, out_valid, rotor);
  modport slave (input in, setting, in_valid, load, start_pos, out_ready,
                 output in_ready, out, out_valid, rotor);
endinterface

// File: rtl/mem_decoder.sv
// mem_decoder: MEM rotor-cipher decoder feeding an output FIFO.
// Define MEM_DECODER_LOWERCASE_EN to also decode 'a'..'z'.
module mem_decoder #(
  parameter int FIFO_DEPTH = 4,
  parameter int OFF0 = 3,
  parameter int OFF1 = 7,
  parameter int OFF2 = 11,
  parameter int OFF3 = 19
) (
  input logic clk,
  input logic reset,
  mem_decoder_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = FIFO_DEPTH[AW:0];
  localparam logic [AW:0] ONE_C = 1;
  typedef enum logic [1:0] {EMPTY, PARTIAL, FULL} state_t;
  state_t state, state_n;
  logic [AW:0] cnt, cnt_n;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [7:0] mem [FIFO_DEPTH];
  logic [4:0] rotor_q, off, start, idx, p;
  logic [6:0] t;
  logic [7:0] dec;
  logic ready_q, push, pop, is_uc, is_lc, letter;
  assign bus.in_ready = ready_q && state != FULL;
  assign bus.out_valid = state != EMPTY;
  assign bus.out = bus.out_valid ? mem[rd_ptr] : 8'h00;
  assign bus.rotor = rotor_q;
  assign push = bus.in_valid && bus.in_ready;
  assign pop = bus.out_valid && bus.out_ready;
  assign is_uc = bus.in >= 8'h41 && bus.in <= 8'h5A;
`ifdef MEM_DECODER_LOWERCASE_EN
  assign is_lc = bus.in >= 8'h61 && bus.in <= 8'h7A;
`else
  assign is_lc = 1'b0;
`endif
  assign letter = is_uc || is_lc;
  // 'A' and 'a' share low five bits 5'd1, so the letter index and case come straight from the byte
  always_comb begin
    off = bus.setting == 2'd0 ? 5'(OFF0) : bus.setting == 2'd1 ? 5'(OFF1) :
          bus.setting == 2'd2 ? 5'(OFF2) : 5'(OFF3);
    idx = bus.in[4:0] - 5'd1;
    t = 7'd52 + {2'b0, idx} - {2'b0, off} - {2'b0, rotor_q};
    p = t >= 7'd52 ? 5'(t - 7'd52) : t >= 7'd26 ? 5'(t - 7'd26) : 5'(t);
    dec = letter ? {bus.in[7:5], p + 5'd1} : bus.in;
    start = bus.start_pos > 5'd25 ? bus.start_pos - 5'd26 : bus.start_pos;
  end
  always_comb begin
    cnt_n = push && !pop ? cnt + ONE_C : pop && !push ? cnt - ONE_C : cnt;
    state_n = cnt_n == '0 ? EMPTY : cnt_n == DEPTH_C ? FULL : PARTIAL;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= EMPTY;
      cnt <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      rotor_q <= '0;
      ready_q <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      ready_q <= 1'b1;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      if (bus.load) rotor_q <= start;
      else if (push && letter) rotor_q <= rotor_q == 5'd25 ? 5'd0 : rotor_q + 5'd1;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= dec;
  end
endmodule

// File: tb/tb_mem_decoder.sv
// tb_mem_decoder: directed and random stimulus against a queue-based cipher model.
module tb_mem_decoder;
  localparam int DEPTH = 4;
`ifdef MEM_DECODER_LOWERCASE_EN
  localparam bit LC = 1'b1;
`else
  localparam bit LC = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  logic [7:0] q[$];
  int mrot = 0;
  bit mrdy = 1'b0;
  mem_decoder_if bus ();
  mem_decoder #(.FIFO_DEPTH(DEPTH)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic bit is_letter(input logic [7:0] c);
    return (c >= 8'h41 && c <= 8'h5A) || (LC && c >= 8'h61 && c <= 8'h7A);
  endfunction
  function automatic logic [7:0] model_dec(input logic [7:0] c, input logic [1:0] s, input int r);
    int off, base, v;
    if (!is_letter(c)) return c;
    off = s == 0 ? 3 : s == 1 ? 7 : s == 2 ? 11 : 19;
    base = c <= 8'h5A ? 65 : 97;
    v = (int'(c) - base - off - r) % 26;
    if (v < 0) v += 26;
    return 8'(base + v);
  endfunction
  task automatic step(input logic v, input logic [7:0] c, input logic [1:0] s,
                      input logic ld, input logic [4:0] sp, input logic ordy);
    bit push, pop;
    @(negedge clk);
    check("in_ready", bus.in_ready, mrdy && q.size() < DEPTH);
    check("out_valid", bus.out_valid, q.size() > 0);
    if (q.size() > 0) check("out", bus.out, q[0]);
    check("rotor", bus.rotor, mrot);
    bus.in_valid = v; bus.in = c; bus.setting = s;
    bus.load = ld; bus.start_pos = sp; bus.out_ready = ordy;
    push = v && mrdy && q.size() < DEPTH;
    pop = q.size() > 0 && ordy;
    if (pop) void'(q.pop_front());
    if (push) q.push_back(model_dec(c, s, mrot));
    if (ld) mrot = sp > 25 ? int'(sp) - 26 : int'(sp);
    else if (push && is_letter(c)) mrot = (mrot + 1) % 26;
    mrdy = 1'b1;
    @(posedge clk);
  endtask
  task automatic idle(input logic ordy);
    step(1'b0, 8'h00, 2'd0, 1'b0, 5'd0, ordy);
  endtask
  initial begin
    logic [7:0] c;
    bus.in_valid = 0; bus.in = 0; bus.setting = 0;
    bus.load = 0; bus.start_pos = 0; bus.out_ready = 0;
    #1;
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out", bus.out, 0);
    check("rst_rotor", bus.rotor, 0);
    @(posedge clk); #1 reset = 0;
    check("rel_in_ready", bus.in_ready, 0);
    idle(1'b1);
    step(1'b1, "K", 2'd0, 1'b0, 5'd0, 1'b1);
    #1 check("k_to_h", bus.out, "H");
    check("rot1", bus.rotor, 1);
    step(1'b1, "M", 2'd1, 1'b0, 5'd0, 1'b1);
    #1 check("m_to_e", bus.out, "E");
    check("rot2", bus.rotor, 2);
    idle(1'b1);
    step(1'b0, 8'h00, 2'd0, 1'b1, 5'd25, 1'b1);
    step(1'b1, "A", 2'd3, 1'b0, 5'd0, 1'b1);
    #1 check("a_to_i", bus.out, "I");
    check("rot_wrap", bus.rotor, 0);
    step(1'b0, 8'h00, 2'd0, 1'b1, 5'd31, 1'b1);
    #1 check("load31", bus.rotor, 5);
    step(1'b0, 8'h00, 2'd0, 1'b1, 5'd4, 1'b1);
    step(1'b1, 8'h20, 2'd0, 1'b0, 5'd0, 1'b1);
    #1 check("space", bus.out, 8'h20);
    check("space_rot", bus.rotor, 4);
    step(1'b1, "a", 2'd0, 1'b0, 5'd0, 1'b1);
    #1 check("lower_a", bus.out, LC ? "t" : "a");
    check("lower_rot", bus.rotor, LC ? 5 : 4);
    step(1'b1, "Q", 2'd2, 1'b1, 5'd9, 1'b1);
    #1 check("load_vs_step", bus.rotor, 9);
    idle(1'b1);
    idle(1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, 8'(86 + i), 2'd1, 1'b0, 5'd0, 1'b0);
    #1 check("full_block", bus.in_ready, 0);
    for (int i = 0; i < 4; i++) step(1'b1, "Z", 2'd1, 1'b0, 5'd0, 1'b0);
    while (q.size() < DEPTH + 1 && q[q.size() - 1] == 8'h00) idle(1'b1);
    for (int i = 0; i < 8; i++) step(q.size() < DEPTH, "Z", 2'd1, 1'b0, 5'd0, 1'b1);
    for (int i = 0; i < 6; i++) idle(1'b1);
    step(1'b1, "B", 2'd0, 1'b0, 5'd0, 1'b0);
    step(1'b1, "C", 2'd0, 1'b0, 5'd0, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b1, 8'(68 + i), 2'(i), 1'b0, 5'd0, 1'b1);
    #1 check("steady_in_ready", bus.in_ready, 1);
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 3))
        0: c = 8'($urandom_range(65, 90));
        1: c = 8'($urandom_range(97, 122));
        2: c = 8'($urandom_range(0, 255));
        default: c = 8'($urandom_range(65, 90));
      endcase
      step($urandom_range(0, 3) != 0, c, 2'($urandom), $urandom_range(0, 9) == 0,
           5'($urandom), $urandom_range(0, 2) != 0);
    end
    for (int i = 0; i < 6; i++) idle(1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 8'(80 + i), 2'd0, 1'b0, 5'd0, 1'b0);
    bus.in_valid = 0; bus.load = 0;
    @(negedge clk); #2 reset = 1;
    #1 check("mid_rst_out_valid", bus.out_valid, 0);
    check("mid_rst_rotor", bus.rotor, 0);
    check("mid_rst_in_ready", bus.in_ready, 0);
    q.delete(); mrot = 0; mrdy = 1'b0;
    @(posedge clk); #1 reset = 0;
    for (int i = 0; i < 4; i++) idle(1'b1);
    step(1'b1, "K", 2'd0, 1'b0, 5'd0, 1'b1);
    #1 check("post_rst_h", bus.out, "H");
    idle(1'b1);
    idle(1'b1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
